// File: rtl/if_id_inst_buffer.sv
// Instruction buffer between fetch and decode: a small FIFO of {pc, inst, excp}
// entries with valid/ready handshakes on both sides and a flush that empties it.
module if_id_inst_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_excp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_excp,
  output logic [PTR_W:0]   count
);

  localparam int ENTRY_W = 65;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Ready depends only on occupancy so IF never sees a combinational path from ID.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign head     = mem[rd_ptr];
  assign out_pc   = head[64:33];
  assign out_inst = head[32:1];
  assign out_excp = head[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {in_pc, in_inst, in_excp};
    end
  end

  // Flush only rewinds the pointers; stale storage is harmless once count is 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_inst_buffer.sv
// Self-checking bench for if_id_inst_buffer: a queue of expected entries is filled
// on every accepted push and compared against out_* on every accepted pop.
module tb_if_id_inst_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_excp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;
  logic [2:0]  count;

  logic [64:0] exp_q[$];
  int          total_checks;
  int          passed_checks;

  if_id_inst_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_excp(in_excp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_excp(out_excp),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus, driven at the falling edge; accepted pops are scored here.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic excp, input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_excp   = excp;
    out_ready = rdy;
    flush     = fl;
    #1;
    do_push = v && (exp_q.size() != DEPTH) && !fl;
    do_pop  = (exp_q.size() != 0) && rdy && !fl;
    if (do_pop) begin
      total_checks++;
      if ({out_pc, out_inst, out_excp} !== exp_q[0])
        $display("FAIL pop_entry: got %h expected %h", {out_pc, out_inst, out_excp}, exp_q[0]);
      else
        passed_checks++;
    end
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, inst, excp});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_excp = 1'b0;
    #12;
    total_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed_checks++;
    total_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed_checks++;
    total_checks++;
    if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count);
    else passed_checks++;
    total_checks++;
    if ({out_pc, out_inst, out_excp} !== 65'd0)
      $display("FAIL reset_out_data: got %h expected 0", {out_pc, out_inst, out_excp});
    else passed_checks++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    tick(1'b1, 32'h1c000000, 32'h02800421, 1'b0, 1'b0, 1'b0);
    total_checks++;
    if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid);
    else passed_checks++;
    total_checks++;
    if (out_pc !== 32'h1c000000) $display("FAIL single_out_pc: got %h expected 1c000000", out_pc);
    else passed_checks++;
    total_checks++;
    if (out_inst !== 32'h02800421) $display("FAIL single_out_inst: got %h expected 02800421", out_inst);
    else passed_checks++;
    total_checks++;
    if (count !== 3'd1) $display("FAIL single_count: got %0d expected 1", count);
    else passed_checks++;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_drained: got %b expected 0", out_valid);
    else passed_checks++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++)
      tick(1'b1, 32'h1c000000 + 32'(i * 4), 32'h00100000 + 32'(i), 1'b0, 1'b0, 1'b0);
    total_checks++;
    if (count !== 3'd4) $display("FAIL full_count: got %0d expected 4", count);
    else passed_checks++;
    total_checks++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b expected 0", in_ready);
    else passed_checks++;
    tick(1'b1, 32'h1c000010, 32'hdeadbeef, 1'b0, 1'b0, 1'b0);
    total_checks++;
    if (count !== 3'd4) $display("FAIL full_drop_count: got %0d expected 4", count);
    else passed_checks++;
    // Full with out_ready=1: the pop happens but the offered entry is still refused.
    tick(1'b1, 32'h1c000014, 32'hbadc0de0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if (count !== 3'd3) $display("FAIL full_pop_nopush_count: got %0d expected 3", count);
    else passed_checks++;
    for (int i = 0; i < 3; i++)
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if (count !== 3'd0) $display("FAIL drain_count: got %0d expected 0", count);
    else passed_checks++;
    total_checks++;
    if (out_valid !== 1'b0) $display("FAIL drain_out_valid: got %b expected 0", out_valid);
    else passed_checks++;
    // Empty: out_ready alone must not move anything.
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if (count !== 3'd0) $display("FAIL empty_pop_count: got %0d expected 0", count);
    else passed_checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    pc = 32'h1c001000;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, pc, pc ^ 32'h5a5a0000, 1'b0, 1'b0, 1'b0);
      pc += 32'd4;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, pc, pc ^ 32'h5a5a0000, 1'b0, 1'b1, 1'b0);
      pc += 32'd4;
      total_checks++;
      if (count !== 3'd2) $display("FAIL b2b_count: got %0d expected 2", count);
      else passed_checks++;
    end
    for (int i = 0; i < 2; i++)
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if (count !== 3'd0) $display("FAIL b2b_drain_count: got %0d expected 0", count);
    else passed_checks++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++)
      tick(1'b1, 32'h1c002000 + 32'(i * 4), 32'h11110000 + 32'(i), 1'b0, 1'b0, 1'b0);
    tick(1'b1, 32'h1c00200c, 32'hffffffff, 1'b0, 1'b1, 1'b1);
    total_checks++;
    if (count !== 3'd0) $display("FAIL flush_count: got %0d expected 0", count);
    else passed_checks++;
    total_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid);
    else passed_checks++;
    total_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    else passed_checks++;
    tick(1'b1, 32'h1c008000, 32'h22220000, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if (count !== 3'd0) $display("FAIL flush_resume_count: got %0d expected 0", count);
    else passed_checks++;
  endtask

  task automatic test_excp();
    tick(1'b1, 32'h1c000002, 32'h03400000, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 32'h1c000008, 32'h03400001, 1'b0, 1'b0, 1'b0);
    total_checks++;
    if ({out_excp, out_pc} !== {1'b1, 32'h1c000002})
      $display("FAIL excp_head: got %b/%h expected 1/1c000002", out_excp, out_pc);
    else passed_checks++;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total_checks++;
    if ({out_excp, out_pc} !== {1'b0, 32'h1c000008})
      $display("FAIL excp_next: got %b/%h expected 0/1c000008", out_excp, out_pc);
    else passed_checks++;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++)
      tick(1'b1, 32'h1c003000 + 32'(i * 4), 32'h33330000 + 32'(i), 1'b0, 1'b0, 1'b0);
    total_checks++;
    if (count !== 3'd3) $display("FAIL pre_reset_count: got %0d expected 3", count);
    else passed_checks++;
    #2;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    total_checks++;
    if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %b expected 0", out_valid);
    else passed_checks++;
    total_checks++;
    if (count !== 3'd0) $display("FAIL async_count: got %0d expected 0", count);
    else passed_checks++;
    total_checks++;
    if (in_ready !== 1'b1) $display("FAIL async_in_ready: got %b expected 1", in_ready);
    else passed_checks++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tick(1'b1, 32'h1c004000, 32'h44440000, 1'b0, 1'b0, 1'b0);
    total_checks++;
    if (count !== 3'd1) $display("FAIL post_reset_count: got %0d expected 1", count);
    else passed_checks++;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_excp();
    test_async_reset();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
